// File: rtl/pico_axi_read_arbiter.sv
// pico_axi_read_arbiter
// Shares one AXI4 read master port among NUM_PORTS requesters. AR requests are
// granted round-robin into a single registered AR stage, and the port index is
// prepended to the ID. R beats are routed back by those ID bits with no storage.
// A per-port outstanding-burst counter keeps any one requester from filling
// the shared return path.
module pico_axi_read_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int C_AXI_ID_WIDTH   = 8,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 128,
  parameter int MAX_OUTSTANDING  = 8,
  localparam int PORT_BITS       = $clog2(NUM_PORTS),
  localparam int M_ID_WIDTH      = C_AXI_ID_WIDTH + PORT_BITS
) (
  input  logic                                   aclk,
  input  logic                                   aresetn,
  // requester-side AR channels, packed per port
  input  logic [NUM_PORTS*C_AXI_ID_WIDTH-1:0]    s_axi_arid,
  input  logic [NUM_PORTS*C_AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic [NUM_PORTS*8-1:0]                 s_axi_arlen,
  input  logic [NUM_PORTS-1:0]                   s_axi_arvalid,
  output logic [NUM_PORTS-1:0]                   s_axi_arready,
  // requester-side R channel (payload shared, valid/ready per port)
  output logic [C_AXI_ID_WIDTH-1:0]              s_axi_rid,
  output logic [C_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rlast,
  output logic [NUM_PORTS-1:0]                   s_axi_rvalid,
  input  logic [NUM_PORTS-1:0]                   s_axi_rready,
  // master-side AR channel
  output logic [M_ID_WIDTH-1:0]                  m_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                             m_axi_arlen,
  output logic                                   m_axi_arvalid,
  input  logic                                   m_axi_arready,
  // master-side R channel
  input  logic [M_ID_WIDTH-1:0]                  m_axi_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                             m_axi_rresp,
  input  logic                                   m_axi_rlast,
  input  logic                                   m_axi_rvalid,
  output logic                                   m_axi_rready,
  output logic                                   outstanding_any
);

  // Wide enough for MAX_OUTSTANDING up to 15.
  localparam int CNT_W = 4;

  logic [NUM_PORTS-1:0]        eligible;
  logic [NUM_PORTS-1:0]        cnt_nonzero;
  logic [PORT_BITS-1:0]        rr_ptr_reg;
  logic [PORT_BITS-1:0]        grant;
  logic [PORT_BITS-1:0]        scan_idx;
  logic                        grant_valid;
  logic                        ar_load_ok;
  logic [PORT_BITS-1:0]        r_sel;

  logic [M_ID_WIDTH-1:0]       arid_reg;
  logic [C_AXI_ADDR_WIDTH-1:0] araddr_reg;
  logic [7:0]                  arlen_reg;
  logic                        arvalid_reg;

  // The AR stage can take a new request when empty or when its current one
  // is being accepted this cycle.
  assign ar_load_ok = !arvalid_reg || m_axi_arready;

  // Return-path routing uses the port bits prepended to the ID.
  assign r_sel        = m_axi_rid[M_ID_WIDTH-1 -: PORT_BITS];
  assign m_axi_rready = s_axi_rready[r_sel];
  assign s_axi_rid    = m_axi_rid[C_AXI_ID_WIDTH-1:0];
  assign s_axi_rdata  = m_axi_rdata;
  assign s_axi_rresp  = m_axi_rresp;
  assign s_axi_rlast  = m_axi_rlast;

  assign m_axi_arid      = arid_reg;
  assign m_axi_araddr    = araddr_reg;
  assign m_axi_arlen     = arlen_reg;
  assign m_axi_arvalid   = arvalid_reg;
  assign outstanding_any = |cnt_nonzero;

  // Round-robin scan from rr_ptr upward; scanning offsets high-to-low lets the
  // smallest offset win, and the index wraps naturally since NUM_PORTS is 2^n.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    scan_idx    = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      scan_idx = rr_ptr_reg + PORT_BITS'(i);
      if (eligible[scan_idx]) begin
        grant       = scan_idx;
        grant_valid = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [CNT_W-1:0] cnt_reg;
      logic             ar_hs;
      logic             r_last_hs;

      assign eligible[gi]    = s_axi_arvalid[gi] && (cnt_reg < CNT_W'(MAX_OUTSTANDING));
      // Ready is held low while reset is asserted so no handshake is implied.
      assign s_axi_arready[gi] = aresetn && ar_load_ok && grant_valid &&
                                 (grant == PORT_BITS'(gi));
      assign ar_hs           = s_axi_arready[gi];
      assign s_axi_rvalid[gi] = m_axi_rvalid && (r_sel == PORT_BITS'(gi));
      assign r_last_hs       = s_axi_rvalid[gi] && m_axi_rready && m_axi_rlast;
      assign cnt_nonzero[gi] = (cnt_reg != '0);

      // Outstanding-burst counter: +1 on AR accept, -1 on rlast, saturating at 0.
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          cnt_reg <= '0;
        end else if (ar_hs && !r_last_hs) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end else if (!ar_hs && r_last_hs && (cnt_reg != '0)) begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end
    end
  endgenerate

  // Registered AR stage and round-robin pointer; contents hold while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arvalid_reg <= 1'b0;
      arid_reg    <= '0;
      araddr_reg  <= '0;
      arlen_reg   <= '0;
      rr_ptr_reg  <= '0;
    end else if (ar_load_ok) begin
      if (grant_valid) begin
        arvalid_reg <= 1'b1;
        arid_reg    <= {grant, s_axi_arid[grant*C_AXI_ID_WIDTH +: C_AXI_ID_WIDTH]};
        araddr_reg  <= s_axi_araddr[grant*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
        arlen_reg   <= s_axi_arlen[grant*8 +: 8];
        rr_ptr_reg  <= grant + PORT_BITS'(1);
      end else begin
        arvalid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pico_axi_read_arbiter.sv
// Directed bench for pico_axi_read_arbiter (4 ports, outstanding limit 2).
module tb_pico_axi_read_arbiter;
  localparam int N  = 4;
  localparam int IW = 8;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int MO = 2;
  localparam int PB = 2;
  localparam int MW = IW + PB;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [N*IW-1:0]   s_axi_arid;
  logic [N*AW-1:0]   s_axi_araddr;
  logic [N*8-1:0]    s_axi_arlen;
  logic [N-1:0]      s_axi_arvalid;
  logic [N-1:0]      s_axi_arready;
  logic [IW-1:0]     s_axi_rid;
  logic [DW-1:0]     s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic [N-1:0]      s_axi_rvalid;
  logic [N-1:0]      s_axi_rready;
  logic [MW-1:0]     m_axi_arid;
  logic [AW-1:0]     m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [MW-1:0]     m_axi_rid;
  logic [DW-1:0]     m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic              outstanding_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  pico_axi_read_arbiter #(
    .NUM_PORTS(N), .C_AXI_ID_WIDTH(IW), .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .outstanding_any(outstanding_any)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic set_ar(input int p, input logic v, input logic [7:0] id,
                        input logic [31:0] addr, input logic [7:0] len);
    s_axi_arvalid[p]          = v;
    s_axi_arid[p*IW +: IW]    = id;
    s_axi_araddr[p*AW +: AW]  = addr;
    s_axi_arlen[p*8 +: 8]     = len;
    if (v) $display("AR req  port %0d id %02h addr %08h len %0d", p, id, addr, len);
  endtask

  task automatic drive_r(input logic v, input int p, input logic [7:0] id,
                         input logic last, input logic [127:0] data);
    m_axi_rvalid = v;
    m_axi_rid    = {p[PB-1:0], id};
    m_axi_rlast  = last;
    m_axi_rdata  = data;
    m_axi_rresp  = 2'b00;
    if (v) $display("R beat  port %0d id %02h last %0d data %0h", p, id, last, data);
  endtask

  task automatic clear_inputs();
    s_axi_arvalid = '0;
    s_axi_arid    = '0;
    s_axi_araddr  = '0;
    s_axi_arlen   = '0;
    s_axi_rready  = '1;
    m_axi_rvalid  = 1'b0;
    m_axi_rid     = '0;
    m_axi_rdata   = '0;
    m_axi_rresp   = '0;
    m_axi_rlast   = 1'b0;
  endtask

  task automatic reset_pulse();
    clear_inputs();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
  endtask

  initial begin
    aresetn       = 1'b0;
    m_axi_arready = 1'b1;
    clear_inputs();
    step();
    step();

    // Reset state
    check_val("rst_arvalid", 128'(m_axi_arvalid), 128'd0);
    check_val("rst_arid", 128'(m_axi_arid), 128'd0);
    check_val("rst_araddr", 128'(m_axi_araddr), 128'd0);
    check_val("rst_arlen", 128'(m_axi_arlen), 128'd0);
    check_val("rst_arready", 128'(s_axi_arready), 128'd0);
    check_val("rst_outstanding", 128'(outstanding_any), 128'd0);
    aresetn = 1'b1;

    // Single request from port 2
    set_ar(2, 1'b1, 8'h5A, 32'h1000, 8'd3);
    settle();
    check_val("single_arready", 128'(s_axi_arready), 128'b0100);
    step();
    set_ar(2, 1'b0, 8'h00, 32'h0, 8'd0);
    settle();
    check_val("single_arvalid", 128'(m_axi_arvalid), 128'd1);
    check_val("single_arid", 128'(m_axi_arid), 128'h25A);
    check_val("single_araddr", 128'(m_axi_araddr), 128'h1000);
    check_val("single_arlen", 128'(m_axi_arlen), 128'd3);
    check_val("single_arready_low", 128'(s_axi_arready), 128'd0);
    check_val("single_outstanding", 128'(outstanding_any), 128'd1);
    step();
    check_val("single_drain", 128'(m_axi_arvalid), 128'd0);

    // R beats for port 2; first beat held off by the requester
    s_axi_rready = 4'b1011;
    drive_r(1'b1, 2, 8'h5A, 1'b0, 128'hA0);
    settle();
    check_val("r_rvalid_route", 128'(s_axi_rvalid), 128'b0100);
    check_val("r_rready_stall", 128'(m_axi_rready), 128'd0);
    step();
    s_axi_rready = '1;
    for (int b = 0; b < 4; b++) begin
      drive_r(1'b1, 2, 8'h5A, (b == 3), 128'hA0 + 128'(b));
      settle();
      check_val("r_rvalid", 128'(s_axi_rvalid), 128'b0100);
      check_val("r_rid", 128'(s_axi_rid), 128'h5A);
      check_val("r_rdata", s_axi_rdata, 128'hA0 + 128'(b));
      check_val("r_rlast", 128'(s_axi_rlast), 128'(b == 3));
      check_val("r_outstanding", 128'(outstanding_any), 128'd1);
      step();
    end
    drive_r(1'b0, 0, 8'h00, 1'b0, 128'h0);
    settle();
    check_val("r_outstanding_done", 128'(outstanding_any), 128'd0);

    // Fairness: all ports requesting; rlast traffic keeps counters at zero
    reset_pulse();
    for (int p = 0; p < N; p++) set_ar(p, 1'b1, 8'(8'h10 + p), 32'(32'h100 * p), 8'd0);
    for (int k = 0; k < 16; k++) begin
      drive_r(1'b1, k % N, 8'h00, 1'b1, 128'(k));
      settle();
      check_val("fair_arready", 128'(s_axi_arready), 128'(4'b0001 << (k % N)));
      step();
      check_val("fair_arid", 128'(m_axi_arid), 128'({2'(k % N), 8'(8'h10 + (k % N))}));
    end
    clear_inputs();
    step();

    // Backpressure: master stalls AR for 5 cycles while full
    m_axi_arready = 1'b0;
    set_ar(0, 1'b1, 8'h11, 32'h2000, 8'd1);
    set_ar(1, 1'b1, 8'h22, 32'h3000, 8'd2);
    settle();
    check_val("bp_grant0", 128'(s_axi_arready), 128'b0001);
    step();
    set_ar(0, 1'b0, 8'h00, 32'h0, 8'd0);
    for (int c = 0; c < 5; c++) begin
      settle();
      check_val("bp_arready_low", 128'(s_axi_arready), 128'd0);
      check_val("bp_arvalid", 128'(m_axi_arvalid), 128'd1);
      check_val("bp_arid", 128'(m_axi_arid), 128'h011);
      check_val("bp_araddr", 128'(m_axi_araddr), 128'h2000);
      step();
    end
    m_axi_arready = 1'b1;
    settle();
    check_val("bp_grant1", 128'(s_axi_arready), 128'b0010);
    step();
    set_ar(1, 1'b0, 8'h00, 32'h0, 8'd0);
    check_val("bp_arid1", 128'(m_axi_arid), 128'h122);
    check_val("bp_araddr1", 128'(m_axi_araddr), 128'h3000);
    check_val("bp_arlen1", 128'(m_axi_arlen), 128'd2);
    step();
    check_val("bp_no_dup", 128'(m_axi_arvalid), 128'd0);

    // Outstanding cap of 2 on port 0
    reset_pulse();
    set_ar(0, 1'b1, 8'h33, 32'h4000, 8'd0);
    settle();
    check_val("cap_first", 128'(s_axi_arready), 128'b0001);
    step();
    settle();
    check_val("cap_second", 128'(s_axi_arready), 128'b0001);
    step();
    set_ar(1, 1'b1, 8'h44, 32'h4100, 8'd0);
    settle();
    check_val("cap_port1_passes", 128'(s_axi_arready), 128'b0010);
    step();
    set_ar(1, 1'b0, 8'h44, 32'h0, 8'd0);
    settle();
    check_val("cap_port0_stalled", 128'(s_axi_arready), 128'd0);
    step();
    drive_r(1'b1, 0, 8'h33, 1'b1, 128'h5);
    settle();
    check_val("cap_rlast_cycle", 128'(s_axi_arready), 128'd0);
    check_val("cap_rlast_route", 128'(s_axi_rvalid), 128'b0001);
    step();
    drive_r(1'b0, 0, 8'h00, 1'b0, 128'h0);
    settle();
    check_val("cap_reissue", 128'(s_axi_arready), 128'b0001);
    step();
    set_ar(0, 1'b0, 8'h00, 32'h0, 8'd0);
    check_val("cap_reissue_arid", 128'(m_axi_arid), 128'h033);
    step();

    // Same-cycle AR and rlast on port 1 (count 1 stays 1)
    set_ar(1, 1'b1, 8'h44, 32'h4200, 8'd0);
    drive_r(1'b1, 1, 8'h44, 1'b1, 128'h6);
    settle();
    check_val("sim_grant", 128'(s_axi_arready), 128'b0010);
    step();
    drive_r(1'b0, 0, 8'h00, 1'b0, 128'h0);
    settle();
    check_val("sim_one_more", 128'(s_axi_arready), 128'b0010);
    step();
    settle();
    check_val("sim_now_capped", 128'(s_axi_arready), 128'd0);
    step();
    set_ar(1, 1'b0, 8'h00, 32'h0, 8'd0);

    // rlast to port 3 with zero count: forwarded, counter stays 0
    drive_r(1'b1, 3, 8'h77, 1'b1, 128'hDEAD_BEEF);
    settle();
    check_val("sat_rvalid", 128'(s_axi_rvalid), 128'b1000);
    check_val("sat_rid", 128'(s_axi_rid), 128'h77);
    check_val("sat_rdata", s_axi_rdata, 128'hDEAD_BEEF);
    check_val("sat_rready", 128'(m_axi_rready), 128'd1);
    step();
    drive_r(1'b0, 0, 8'h00, 1'b0, 128'h0);
    set_ar(3, 1'b1, 8'h78, 32'h6000, 8'd0);
    settle();
    check_val("sat_req1", 128'(s_axi_arready), 128'b1000);
    step();
    settle();
    check_val("sat_req2", 128'(s_axi_arready), 128'b1000);
    step();
    settle();
    check_val("sat_req3_capped", 128'(s_axi_arready), 128'd0);
    step();
    set_ar(3, 1'b0, 8'h00, 32'h0, 8'd0);

    // Asynchronous reset while full with counters non-zero
    m_axi_arready = 1'b0;
    set_ar(2, 1'b1, 8'h66, 32'h5000, 8'd0);
    settle();
    check_val("ar_rst_grant", 128'(s_axi_arready), 128'b0100);
    step();
    set_ar(2, 1'b0, 8'h00, 32'h0, 8'd0);
    settle();
    check_val("ar_rst_full", 128'(m_axi_arvalid), 128'd1);
    check_val("ar_rst_outstanding", 128'(outstanding_any), 128'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check_val("ar_rst_arvalid", 128'(m_axi_arvalid), 128'd0);
    check_val("ar_rst_out_any", 128'(outstanding_any), 128'd0);
    check_val("ar_rst_araddr", 128'(m_axi_araddr), 128'd0);
    for (int p = 0; p < N; p++) set_ar(p, 1'b1, 8'(8'h80 + p), 32'(32'h7000 + p), 8'd0);
    #1;
    check_val("ar_rst_arready", 128'(s_axi_arready), 128'd0);
    step();
    aresetn       = 1'b1;
    m_axi_arready = 1'b1;
    settle();
    check_val("post_rst_grant", 128'(s_axi_arready), 128'b0001);
    step();
    check_val("post_rst_arid", 128'(m_axi_arid), 128'h080);
    clear_inputs();
    step();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pico_axi_read_arbiter.md
# pico_axi_read_arbiter

Shares one AXI4 read master port among NUM_PORTS read requesters, for example several user engines feeding a single PCIe/DDR read path through the read-data downsizer. Read-address requests are granted round-robin into a registered AR stage. Returning R beats are routed back to the owning port using port-index bits prepended to the ID. A per-port outstanding-burst counter caps in-flight reads so that no single requester can monopolise the shared return path.

## Interface
- NUM_PORTS, 4: requester count; power of two, 2..8. PORT_BITS = log2(NUM_PORTS).
- C_AXI_ID_WIDTH, 8: requester-side ID width. Master-side ID width is C_AXI_ID_WIDTH+PORT_BITS.
- C_AXI_ADDR_WIDTH, 32: address width.
- C_AXI_DATA_WIDTH, 128: R data width, identical on both sides.
- MAX_OUTSTANDING, 8: per-port limit on accepted bursts that have not yet received rlast; 1..15.
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axi_arid  in  NUM_PORTS*C_AXI_ID_WIDTH  per-port ARID, packed; port p is in slice p.
- s_axi_araddr  in  NUM_PORTS*C_AXI_ADDR_WIDTH  per-port ARADDR.
- s_axi_arlen  in  NUM_PORTS*8  per-port ARLEN.
- s_axi_arvalid  in  NUM_PORTS  per-port ARVALID.
- s_axi_arready  out  NUM_PORTS  per-port ARREADY; at most one bit is high in any cycle.
- s_axi_rid  out  C_AXI_ID_WIDTH  shared RID, with the port bits stripped.
- s_axi_rdata  out  C_AXI_DATA_WIDTH  shared RDATA.
- s_axi_rresp  out  2  shared RRESP.
- s_axi_rlast  out  1  shared RLAST.
- s_axi_rvalid  out  NUM_PORTS  per-port RVALID.
- s_axi_rready  in  NUM_PORTS  per-port RREADY.
- m_axi_arid  out  C_AXI_ID_WIDTH+PORT_BITS  {port, s_arid}.
- m_axi_araddr, m_axi_arlen, m_axi_arvalid  out  widths as above  registered AR channel.
- m_axi_arready  in  1.
- m_axi_rid  in  C_AXI_ID_WIDTH+PORT_BITS; m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid  in; m_axi_rready  out.
- outstanding_any  out  1  high when any per-port counter is non-zero.

## Operation
- AR register has two states. EMPTY: m_axi_arvalid=0. FULL: m_axi_arvalid=1, holding one request.
- The register may load when it is EMPTY, or when it is FULL and m_axi_arready=1 in that cycle.
- Eligible ports: s_axi_arvalid[p]=1 and cnt[p] < MAX_OUTSTANDING.
- Grant selection:
  - Grant the first eligible port scanning from rr_ptr upward, wrapping at NUM_PORTS.
  - Assert s_axi_arready[grant] combinationally in that cycle, and load {grant, id}, addr and len.
  - Set rr_ptr <= grant+1 (mod NUM_PORTS).
  - If no port is eligible, the register goes EMPTY when its contents are accepted, and rr_ptr is unchanged.
- cnt[p] increments on the s-side AR handshake of port p.
- cnt[p] decrements on an R handshake with rlast=1 whose m_axi_rid top bits equal p.
- If increment and decrement occur in the same cycle, cnt[p] is unchanged.
- A decrement when cnt[p]=0 saturates: the counter stays at 0 and the beat is still forwarded.
- R routing is purely combinational. sel = m_axi_rid[top PORT_BITS].
  - s_axi_rvalid[p] = m_axi_rvalid & (sel==p).
  - m_axi_rready = s_axi_rready[sel].
  - s_axi_rid = m_axi_rid low C_AXI_ID_WIDTH bits. rdata, rresp and rlast pass straight through.
- Beats for different ports may interleave; ordering is whatever the master returns.
- outstanding_any = OR over p of (cnt[p]!=0).

## Timing
- Reset values:
  - m_axi_arvalid=0, m_axi_arid/araddr/arlen=0.
  - s_axi_arready=0, all cnt=0, rr_ptr=0, outstanding_any=0.
  - The R outputs follow their inputs combinationally.
- Reset taken mid-operation clears all state immediately. Bursts already in flight still route by ID, and their rlast decrements saturate at 0.
- AR latency: an s-side handshake at edge N gives m_axi_arvalid=1 after edge N. It is visible to the master in cycle N+1.
- AR throughput: one request per cycle while m_axi_arready=1 and some port is eligible.
- While FULL and m_axi_arready=0: all s_axi_arready=0, and the register contents and m_axi_arvalid are held stable (AXI rule).
- R path latency is 0 cycles; there is no storage on the R path.
- A port that reaches MAX_OUTSTANDING becomes eligible again in the cycle after its rlast handshake.

## Test plan
- Single request: port 2 presents ARID 0x5A, addr 0x1000, len 3, with arready=1. Expect m_axi_arid=0x25A, s_axi_arready[2] for 1 cycle, arvalid 1 cycle later. Then 4 R beats with rid 0x25A reach only s_axi_rvalid[2] with rid 0x5A, and cnt[2] goes 1 then 0 after rlast.
- Fairness: all 4 ports hold arvalid continuously with arready=1. Expect grant order 0,1,2,3,0,1… with no port skipped across 16 grants.
- Backpressure: m_axi_arready=0 for 5 cycles while FULL. Expect the m_axi_ar* outputs stable, all s_axi_arready=0, and nothing lost or duplicated when arready rises.
- Outstanding cap: with MAX_OUTSTANDING=2, port 0 issues 2 bursts with no R traffic. Expect the third request stalled while port 1 requests still pass. One rlast to port 0 lets the third request issue the next cycle.
- Simultaneous events: a port-1 AR handshake and a port-1 rlast in the same cycle leave cnt[1] unchanged. An rlast to a port with cnt=0 is forwarded and its counter stays 0.
- Async reset: assert aresetn=0 between clock edges while FULL with counters non-zero. Expect m_axi_arvalid=0 and outstanding_any=0 without waiting for a clock edge, and the first grant after reset goes to port 0.
